snax_simbacore_csr_sequencer: RTL and testbench

- Sits between the SimbaCore CSR manager's packed read-write CSR outputs and the SimbaCore accelerator datapath.
- Accepts committed configuration sets over the set valid/ready handshake and holds one pending set while a job runs.
- Launches each job with a one-cycle start pulse, keeps its configuration stable until done, and reports status and last-job cycle count as read-only CSRs.

---
 rtl/snax_simbacore_csr_sequencer.sv | 150 +++++++++++++++
 tb/tb_snax_simbacore_csr_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_simbacore_csr_sequencer.sv
// rtl/snax_simbacore_csr_sequencer.sv - job launcher between SimbaCore CSR manager and accelerator datapath
//
// Holds the active configuration for the running job and one pending set.
// Each job starts with a one-cycle acc_start_o pulse. The cycle count and
// status of the last job are reported back as read-only CSRs.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   csr_reg_rw_set_i      NumRwCsr x 32 configuration words, word i at [i*32 +: 32]
//   csr_reg_set_valid_i   configuration set valid
//   csr_reg_set_ready_o   sequencer can accept a set (pending buffer empty)
//   csr_reg_ro_set_o      word0: {job_count[15:0], 14'b0, pend_valid, busy}
//                         word1: cycle count of the last completed job
//   acc_cfg_o             active job configuration, stable from START through RUN
//   acc_start_o           one-cycle job start pulse
//   acc_done_i            one-cycle job completion pulse
module snax_simbacore_csr_sequencer #(
    parameter int unsigned NumRwCsr = 5,
    parameter int unsigned NumRoCsr = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumRwCsr*32-1:0]   csr_reg_rw_set_i,
    input  logic                     csr_reg_set_valid_i,
    output logic                     csr_reg_set_ready_o,
    output logic [NumRoCsr*32-1:0]   csr_reg_ro_set_o,
    output logic [NumRwCsr*32-1:0]   acc_cfg_o,
    output logic                     acc_start_o,
    input  logic                     acc_done_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NumRwCsr*32-1:0]  cfg_q;
    logic [NumRwCsr*32-1:0]  pend_q;
    logic                    pend_valid_q;
    logic                    busy_q;
    logic [31:0]             cyc_cnt_q;
    logic [31:0]             last_cycles_q;
    logic [15:0]             job_cnt_q;

    logic                    accept;
    logic                    load_cfg;
    logic                    cfg_from_pend;
    logic                    pend_load;
    logic                    pend_clr;
    logic                    done_evt;

    assign csr_reg_set_ready_o = ~pend_valid_q;
    assign accept              = csr_reg_set_valid_i & ~pend_valid_q;
    assign done_evt            = (state_q == RUN) & acc_done_i;

    always_comb begin
        state_d       = state_q;
        load_cfg      = 1'b0;
        cfg_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                // A full buffer in IDLE cannot arise from reset, but drain it if it does.
                if (pend_valid_q) begin
                    load_cfg      = 1'b1;
                    cfg_from_pend = 1'b1;
                    pend_clr      = 1'b1;
                    state_d       = START;
                end else if (accept) begin
                    load_cfg = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                // Done is ignored here; a new set arriving now waits in the buffer.
                state_d = RUN;
                if (accept) begin
                    pend_load = 1'b1;
                end
            end
            RUN: begin
                if (acc_done_i) begin
                    if (pend_valid_q) begin
                        load_cfg      = 1'b1;
                        cfg_from_pend = 1'b1;
                        pend_clr      = 1'b1;
                        state_d       = START;
                    end else if (accept) begin
                        load_cfg = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            cyc_cnt_q     <= 32'd0;
            last_cycles_q <= 32'd0;
            job_cnt_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);

            if (load_cfg) begin
                cfg_q <= cfg_from_pend ? pend_q : csr_reg_rw_set_i;
            end

            if (pend_load) begin
                pend_q       <= csr_reg_rw_set_i;
                pend_valid_q <= 1'b1;
            end else if (pend_clr) begin
                pend_valid_q <= 1'b0;
            end

            // Counts START as cycle 1, so the value seen on done is the job length.
            if (load_cfg) begin
                cyc_cnt_q <= 32'd1;
            end else if ((state_q == START || state_q == RUN) && cyc_cnt_q != 32'hFFFF_FFFF) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end

            if (done_evt) begin
                last_cycles_q <= cyc_cnt_q;
                job_cnt_q     <= job_cnt_q + 16'd1;
            end
        end
    end

    assign acc_cfg_o        = cfg_q;
    assign acc_start_o      = (state_q == START);
    assign csr_reg_ro_set_o = {last_cycles_q, job_cnt_q, 14'd0, pend_valid_q, busy_q};

endmodule

// File: tb/tb_snax_simbacore_csr_sequencer.sv
// tb/tb_snax_simbacore_csr_sequencer.sv - self-checking bench for snax_simbacore_csr_sequencer
module tb_snax_simbacore_csr_sequencer;

    localparam int CW = 160;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] rw_set;
    logic          set_valid;
    logic          set_ready;
    logic [63:0]   ro_set;
    logic [CW-1:0] acc_cfg;
    logic          acc_start;
    logic          acc_done;

    int checks = 0;
    int errors = 0;
    int exp_jobs = 0;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_cfg;
    logic          prev_start = 1'b0;

    snax_simbacore_csr_sequencer #(
        .NumRwCsr(5),
        .NumRoCsr(2)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .csr_reg_rw_set_i    (rw_set),
        .csr_reg_set_valid_i (set_valid),
        .csr_reg_set_ready_o (set_ready),
        .csr_reg_ro_set_o    (ro_set),
        .acc_cfg_o           (acc_cfg),
        .acc_start_o         (acc_start),
        .acc_done_i          (acc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mk_cfg(input logic [31:0] base);
        logic [CW-1:0] r;
        for (int i = 0; i < 5; i++) r[i*32 +: 32] = base + i;
        return r;
    endfunction

    // Scoreboard: every start pulse must carry the oldest expected configuration.
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_start) begin
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL start_width: start high two cycles in a row, required one");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: start with cfg %h, required no start", acc_cfg);
                end else begin
                    exp_cfg = exp_q.pop_front();
                    if (acc_cfg !== exp_cfg) begin
                        errors++;
                        $display("FAIL start_cfg: got %h required %h", acc_cfg, exp_cfg);
                    end
                end
            end
            prev_start = acc_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; set_valid = 1'b0; acc_done = 1'b0; rw_set = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (set_ready !== 1'b1 || acc_start !== 1'b0 || ro_set !== 64'd0 || acc_cfg !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b start=%b ro=%h cfg=%h required 1 0 0 0",
                     set_ready, acc_start, ro_set, acc_cfg);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ro_set !== 64'd0 || acc_start !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ro=%h start=%b required 0 0", ro_set, acc_start);
        end
    endtask

    task automatic test_single_job();
        logic [CW-1:0] a;
        a = mk_cfg(32'd1);
        @(negedge clk);                          // cycle 0
        checks++;
        if (set_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b required 1", set_ready);
        end
        rw_set = a; set_valid = 1'b1; exp_q.push_back(a);
        @(negedge clk);                          // cycle 1
        set_valid = 1'b0;
        checks++;
        if (acc_start !== 1'b1) begin
            errors++; $display("FAIL single_start: got %b required 1", acc_start);
        end
        checks++;
        if (ro_set[0] !== 1'b1) begin
            errors++; $display("FAIL single_busy: got %b required 1", ro_set[0]);
        end
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (acc_start !== 1'b0 || acc_cfg !== a) begin
                errors++;
                $display("FAIL single_run_c%0d: start=%b cfg=%h required 0 %h", c, acc_start, acc_cfg, a);
            end
            if (c == 10) acc_done = 1'b1;
        end
        @(negedge clk);                          // cycle 11
        acc_done = 1'b0;
        exp_jobs++;
        checks++;
        if (ro_set[63:32] !== 32'd10) begin
            errors++; $display("FAIL single_cycles: got %0d required 10", ro_set[63:32]);
        end
        checks++;
        if (ro_set[31:16] !== exp_jobs[15:0] || ro_set[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL single_status: jobs=%0d st=%b required %0d 00", ro_set[31:16], ro_set[1:0], exp_jobs);
        end
    endtask

    task automatic test_pending();
        logic [CW-1:0] a, b, c;
        a = mk_cfg($urandom); b = mk_cfg($urandom); c = mk_cfg($urandom);
        @(negedge clk);                          // cycle 0: accept A
        rw_set = a; set_valid = 1'b1; exp_q.push_back(a);
        @(negedge clk);                          // cycle 1: START
        set_valid = 1'b0;
        @(negedge clk);                          // cycle 2: RUN, accept B
        checks++;
        if (set_ready !== 1'b1) begin
            errors++; $display("FAIL pend_ready_b: got %b required 1", set_ready);
        end
        rw_set = b; set_valid = 1'b1; exp_q.push_back(b);
        @(negedge clk);                          // cycle 3: C held, blocked
        rw_set = c;
        checks++;
        if (set_ready !== 1'b0 || ro_set[1] !== 1'b1) begin
            errors++; $display("FAIL pend_full: ready=%b pend=%b required 0 1", set_ready, ro_set[1]);
        end
        @(negedge clk);                          // cycle 4: done for A
        checks++;
        if (set_ready !== 1'b0 || acc_cfg !== a) begin
            errors++; $display("FAIL pend_hold: ready=%b cfg=%h required 0 %h", set_ready, acc_cfg, a);
        end
        acc_done = 1'b1;
        @(negedge clk);                          // cycle 5: START with B, C accepted
        acc_done = 1'b0;
        exp_jobs++;
        checks++;
        if (acc_start !== 1'b1 || set_ready !== 1'b1 || ro_set[1] !== 1'b0) begin
            errors++;
            $display("FAIL pend_launch: start=%b ready=%b pend=%b required 1 1 0", acc_start, set_ready, ro_set[1]);
        end
        exp_q.push_back(c);
        @(negedge clk);                          // cycle 6
        set_valid = 1'b0;
        checks++;
        if (ro_set[1] !== 1'b1 || acc_cfg !== b) begin
            errors++; $display("FAIL pend_c_buffered: pend=%b cfg=%h required 1 %h", ro_set[1], acc_cfg, b);
        end
        @(negedge clk);                          // cycle 7: done for B
        acc_done = 1'b1;
        @(negedge clk);                          // cycle 8: START with C
        acc_done = 1'b0;
        exp_jobs++;
        @(negedge clk);                          // cycle 9: done for C
        acc_done = 1'b1;
        @(negedge clk);                          // cycle 10: IDLE
        acc_done = 1'b0;
        exp_jobs++;
        checks++;
        if (ro_set[63:32] !== 32'd2 || ro_set[31:16] !== exp_jobs[15:0] || ro_set[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL pend_final: cycles=%0d jobs=%0d st=%b required 2 %0d 00",
                     ro_set[63:32], ro_set[31:16], ro_set[1:0], exp_jobs);
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] d, e;
        d = mk_cfg($urandom); e = mk_cfg($urandom);
        @(negedge clk);                          // cycle 0
        rw_set = d; set_valid = 1'b1; exp_q.push_back(d);
        @(negedge clk);                          // cycle 1: START
        set_valid = 1'b0;
        @(negedge clk);                          // cycle 2: RUN
        @(negedge clk);                          // cycle 3: done + accept E
        checks++;
        if (set_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b required 1", set_ready);
        end
        acc_done = 1'b1; rw_set = e; set_valid = 1'b1; exp_q.push_back(e);
        @(negedge clk);                          // cycle 4: START with E
        acc_done = 1'b0; set_valid = 1'b0;
        exp_jobs++;
        checks++;
        if (acc_start !== 1'b1 || ro_set[0] !== 1'b1 || ro_set[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_launch: start=%b busy=%b pend=%b required 1 1 0", acc_start, ro_set[0], ro_set[1]);
        end
        checks++;
        if (ro_set[63:32] !== 32'd3 || ro_set[31:16] !== exp_jobs[15:0]) begin
            errors++;
            $display("FAIL b2b_count: cycles=%0d jobs=%0d required 3 %0d", ro_set[63:32], ro_set[31:16], exp_jobs);
        end
        @(negedge clk);                          // cycle 5: done for E
        acc_done = 1'b1;
        @(negedge clk);                          // cycle 6: IDLE
        acc_done = 1'b0;
        exp_jobs++;
        checks++;
        if (ro_set[0] !== 1'b0 || ro_set[31:16] !== exp_jobs[15:0]) begin
            errors++; $display("FAIL b2b_idle: busy=%b jobs=%0d required 0 %0d", ro_set[0], ro_set[31:16], exp_jobs);
        end
    endtask

    task automatic test_done_in_start();
        logic [CW-1:0] f;
        f = mk_cfg($urandom);
        @(negedge clk);                          // cycle 0
        rw_set = f; set_valid = 1'b1; exp_q.push_back(f);
        @(negedge clk);                          // cycle 1: START, done ignored
        set_valid = 1'b0; acc_done = 1'b1;
        @(negedge clk);                          // cycle 2
        acc_done = 1'b0;
        checks++;
        if (ro_set[0] !== 1'b1 || ro_set[31:16] !== exp_jobs[15:0] || acc_start !== 1'b0) begin
            errors++;
            $display("FAIL start_done_ignored: busy=%b jobs=%0d start=%b required 1 %0d 0",
                     ro_set[0], ro_set[31:16], acc_start, exp_jobs);
        end
        @(negedge clk);                          // cycle 3
        @(negedge clk);                          // cycle 4: real done
        acc_done = 1'b1;
        @(negedge clk);                          // cycle 5
        acc_done = 1'b0;
        exp_jobs++;
        checks++;
        if (ro_set[63:32] !== 32'd4 || ro_set[31:16] !== exp_jobs[15:0] || ro_set[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_done_final: cycles=%0d jobs=%0d busy=%b required 4 %0d 0",
                     ro_set[63:32], ro_set[31:16], ro_set[0], exp_jobs);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [CW-1:0] g, h;
        g = mk_cfg($urandom); h = mk_cfg($urandom);
        @(negedge clk);                          // cycle 0
        rw_set = g; set_valid = 1'b1; exp_q.push_back(g);
        @(negedge clk);                          // cycle 1
        set_valid = 1'b0;
        @(negedge clk);                          // cycle 2: accept H into buffer
        rw_set = h; set_valid = 1'b1;
        @(negedge clk);                          // cycle 3
        set_valid = 1'b0;
        checks++;
        if (ro_set[1] !== 1'b1 || set_ready !== 1'b0) begin
            errors++; $display("FAIL rst_pre: pend=%b ready=%b required 1 0", ro_set[1], set_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_jobs = 0;
        checks++;
        if (acc_start !== 1'b0 || set_ready !== 1'b1 || ro_set !== 64'd0 || acc_cfg !== '0) begin
            errors++;
            $display("FAIL rst_async: start=%b ready=%b ro=%h cfg=%h required 0 1 0 0",
                     acc_start, set_ready, ro_set, acc_cfg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (acc_start !== 1'b0 || set_ready !== 1'b1 || ro_set !== 64'd0) begin
                errors++;
                $display("FAIL rst_quiet_c%0d: start=%b ready=%b ro=%h required 0 1 0", c, acc_start, set_ready, ro_set);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_pending();
        test_back_to_back();
        test_done_in_start();
        test_reset_mid_run();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_starts: %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
